// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared FSM state encoding and default operand width for the shift multiplier and divider
// Exports:
//   DEFAULT_WIDTH - default operand width in bits
//   state_e       - IDLE / RUN / FIX / DONE sequencing states
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration of the divider
// Ports:
//   rem_i  - partial remainder before the step
//   bit_i  - next dividend bit, shifted into the remainder LSB
//   dvs_i  - divisor magnitude
//   rem_o  - partial remainder after the step (restored when the trial goes negative)
//   q_o    - quotient bit produced by the step
//   diff_o - raw low WIDTH bits of the trial subtraction; with rem_i=0 and bit_i=0
//            this is -dvs_i, which the divider reuses for the sign fix-up
module div_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o,
    output logic [WIDTH-1:0] diff_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, dvs_i};
        q_o     = ~trial[WIDTH];
        rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        diff_o  = trial[WIDTH-1:0];
    end

endmodule

// File: rtl/shift_divider.sv
// shift_divider: sequential signed restoring divider, one quotient bit per clock
// Ports:
//   clk         - clock, rising edge
//   rst_n       - synchronous active-low reset
//   start       - request a division (sampled in IDLE only)
//   input1      - signed dividend
//   input2      - signed divisor
//   busy        - high in RUN and FIX
//   done        - one-cycle pulse when results become valid
//   div_by_zero - flag for the last completed operation
//   quotient    - signed quotient, truncated toward zero
//   remainder   - signed remainder, sign of the dividend
module shift_divider
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             fix;
    logic [WIDTH-1:0] st_rem, st_dvs, st_rem_o, st_diff;
    logic             st_bit, st_q;

    // Magnitude capture without an adder: two's complement negation flips
    // every bit above the lowest set bit.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        logic             seen;
        seen = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[i] ^ seen;
            seen = seen | x[i];
        end
        return r;
    endfunction

    // The step's subtractor is the only adder; in FIX it computes 0 - rem_q.
    assign fix    = state_q == FIX;
    assign st_rem = fix ? '0 : rem_q;
    assign st_bit = fix ? 1'b0 : dvd_q[WIDTH-1];
    assign st_dvs = fix ? rem_q : dvs_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (st_rem),
        .bit_i  (st_bit),
        .dvs_i  (st_dvs),
        .rem_o  (st_rem_o),
        .q_o    (st_q),
        .diff_o (st_diff)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        remd_d  = remd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start && input2 == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    remd_d  = input1;
                    dbz_d   = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                    cnt_d   = CW'(WIDTH);
                    dvd_d   = input1[WIDTH-1] ? negate(input1) : input1;
                    dvs_d   = input2[WIDTH-1] ? negate(input2) : input2;
                    rem_d   = '0;
                    qneg_d  = input1[WIDTH-1] ^ input2[WIDTH-1];
                    rneg_d  = input1[WIDTH-1];
                end
            end
            RUN: begin
                // The dividend register doubles as the quotient register.
                rem_d   = st_rem_o;
                dvd_d   = {dvd_q[WIDTH-2:0], st_q};
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q == CW'(1) ? FIX : RUN;
            end
            FIX: begin
                quo_d   = qneg_q ? negate(dvd_q) : dvd_q;
                remd_d  = rneg_q ? st_diff : rem_q;
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d == RUN || state_d == FIX;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            remd_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            remd_q  <= remd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quo_q;
    assign remainder   = remd_q;

endmodule

// File: tb/tb_shift_divider.sv
// tb_shift_divider: directed and random checks of shift_divider against an arithmetic reference
module tb_shift_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] input1 = '0;
    logic [W-1:0] input2 = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .input1      (input1),
        .input2      (input2),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Signed division as plain arithmetic in 64 bits, wrapped to W bits.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sb;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
        end
    endtask

    // Issues one division; lat = edges from the sampling edge until done is seen (0 on timeout).
    // Operands are scrambled right after capture; intf adds an extra start pulse mid-run.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit intf, output int lat);
        bit got;
        got    = 1'b0;
        lat    = 0;
        input1 = a;
        input2 = b;
        start  = 1'b1;
        for (int i = 1; i <= 60 && !got; i++) begin
            step();
            if (i == 1) begin
                start  = 1'b0;
                input1 = $urandom;
                input2 = $urandom;
                chk("busy_after_start", W'(busy), W'(b != '0));
            end
            if (intf && i == 5) begin
                input1 = 32'd1000;
                input2 = 32'd3;
                start  = 1'b1;
            end
            if (intf && i == 6) start = 1'b0;
            if (done) begin
                got = 1'b1;
                lat = i;
            end
        end
        if (got) begin
            step();
            chk("done_one_cycle", W'(done), '0);
            chk("busy_after_done", W'(busy), '0);
        end
    endtask

    int           lat;
    int           pulses;
    logic [W-1:0] eq, er, a, b;
    logic         edz;
    logic [W-1:0] da[3] = '{32'd7, 32'(-7), 32'(-7)};
    logic [W-1:0] db[3] = '{32'(-2), 32'd2, 32'(-2)};
    logic [W-1:0] dq[3] = '{32'(-3), 32'(-3), 32'd3};
    logic [W-1:0] dr[3] = '{32'd1, 32'(-1), 32'(-1)};

    initial begin
        step();
        step();
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_dbz", W'(div_by_zero), '0);
        chk("rst_quo", quotient, '0);
        chk("rst_rem", remainder, '0);
        rst_n = 1'b1;
        step();

        run_div(32'd25, 32'(-5), 1'b0, lat);
        chk("25/-5 lat", W'(lat), 32'd34);
        chk("25/-5 quo", quotient, 32'(-5));
        chk("25/-5 rem", remainder, '0);
        chk("25/-5 dbz", W'(div_by_zero), '0);

        for (int k = 0; k < 3; k++) begin
            run_div(da[k], db[k], 1'b0, lat);
            chk("sign_quo", quotient, dq[k]);
            chk("sign_rem", remainder, dr[k]);
        end

        run_div(32'(-5), '0, 1'b0, lat);
        chk("dbz lat", W'(lat), 32'd1);
        chk("dbz quo", quotient, 32'hFFFF_FFFF);
        chk("dbz rem", remainder, 32'hFFFF_FFFB);
        chk("dbz flag", W'(div_by_zero), 32'd1);

        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
        chk("ovf quo", quotient, 32'h8000_0000);
        chk("ovf rem", remainder, '0);
        chk("ovf dbz", W'(div_by_zero), '0);

        run_div(32'd100, 32'd7, 1'b1, lat);
        chk("ignore_start lat", W'(lat), 32'd34);
        chk("ignore_start quo", quotient, 32'd14);
        chk("ignore_start rem", remainder, 32'd2);
        repeat (3) step();
        chk("hold quo", quotient, 32'd14);
        chk("hold rem", remainder, 32'd2);

        input1 = 32'd50;
        input2 = 32'd3;
        start  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) start = 1'b0;
        end
        chk("run10_busy", W'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_dbz", W'(div_by_zero), '0);
        chk("abort_quo", quotient, '0);
        chk("abort_rem", remainder, '0);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) pulses++;
        end
        chk("abort_no_done", W'(pulses), '0);
        run_div('0, 32'd3, 1'b0, lat);
        chk("post_rst lat", W'(lat), 32'd34);
        chk("post_rst quo", quotient, '0);
        chk("post_rst rem", remainder, '0);

        for (int k = 0; k < 16; k++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = W'($urandom_range(1, 20));
                2: b = -W'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (k == 0) a = 32'h8000_0000;
            model(a, b, eq, er, edz);
            run_div(a, b, 1'b0, lat);
            chk("rand lat", W'(lat), b == '0 ? 32'd1 : 32'd34);
            chk("rand quo", quotient, eq);
            chk("rand rem", remainder, er);
            chk("rand dbz", W'(div_by_zero), W'(edz));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
